// File: rtl/pg_sum_stage.sv
// ---------------------------------------------------------------------------
// pg_sum_stage
//   Post-processing stage of a parallel-prefix adder. Takes the per-bit
//   propagate vector and the prefix group-generate vector from the dot-operator
//   tree. It forms the sum, the carry-out and the signed overflow, and
//   registers them behind a valid/ready handshake. A one-word skid register
//   lets the tree stall without a combinational path from out_ready to
//   in_ready.
//
// Parameters
//   WIDTH      operand / sum width in bits (>= 2)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   stage can accept a word (flop output)
//   p_in       bitwise propagate a^b
//   gg_in      group generate, gg_in[i] = G[i:0] = carry into bit i+1
//   cin        carry into bit 0
//   out_valid  output word valid
//   out_ready  downstream accepts
//   sum_out    registered sum
//   cout_out   registered carry-out
//   ovf_out    registered signed overflow
// ---------------------------------------------------------------------------
module pg_sum_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] gg_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // -------------------------------------------------------------------------
  // Arithmetic
  // -------------------------------------------------------------------------
  // carry[i] is the carry into bit i. carry[WIDTH] is the carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_calc;
  logic             cout_calc;
  logic             ovf_calc;

  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi++) begin : g_carry
      if (gi == 0) begin : g_cin
        assign carry[gi] = cin;
      end else begin : g_gg
        assign carry[gi] = gg_in[gi-1];
      end
    end
  endgenerate

  assign sum_calc  = p_in ^ carry[WIDTH-1:0];
  assign cout_calc = carry[WIDTH];
  // Signed overflow occurs when the carry into the MSB differs from the
  // carry out of it.
  assign ovf_calc  = carry[WIDTH] ^ carry[WIDTH-1];

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic in_ready_reg, out_valid_reg;
  logic in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_reg;
  assign out_xfer = out_valid_reg & out_ready;

  // State register. The handshake flags are registered here from the next
  // state, so in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next != SKID);
      out_valid_reg <= (state_next != EMPTY);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (in_xfer) state_next = FULL;
      end
      FULL: begin
        if (in_xfer && !out_xfer)      state_next = SKID;
        else if (!in_xfer && out_xfer) state_next = EMPTY;
      end
      SKID: begin
        if (out_xfer) state_next = FULL;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Output / datapath-control logic
  logic load_main_in, load_main_skid, load_skid;

  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      EMPTY: load_main_in = in_xfer;
      FULL: begin
        // A new word replaces the main word only if the main word leaves
        // in the same cycle. Otherwise the new word parks in the skid.
        load_main_in = in_xfer & out_xfer;
        load_skid    = in_xfer & ~out_xfer;
      end
      SKID: load_main_skid = out_xfer;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Main and skid registers
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_reg, skid_sum_reg;
  logic             cout_reg, skid_cout_reg;
  logic             ovf_reg, skid_ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      skid_sum_reg  <= '0;
      skid_cout_reg <= 1'b0;
      skid_ovf_reg  <= 1'b0;
    end else begin
      if (load_main_in) begin
        sum_reg  <= sum_calc;
        cout_reg <= cout_calc;
        ovf_reg  <= ovf_calc;
      end else if (load_main_skid) begin
        sum_reg  <= skid_sum_reg;
        cout_reg <= skid_cout_reg;
        ovf_reg  <= skid_ovf_reg;
      end
      if (load_skid) begin
        skid_sum_reg  <= sum_calc;
        skid_cout_reg <= cout_calc;
        skid_ovf_reg  <= ovf_calc;
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum_out   = sum_reg;
  assign cout_out  = cout_reg;
  assign ovf_out   = ovf_reg;

endmodule

// File: tb/tb_pg_sum_stage.sv
// ---------------------------------------------------------------------------
// tb_pg_sum_stage
//   Directed and randomised tests for pg_sum_stage with WIDTH=8. Each scenario
//   is a task with its own comparisons. Inputs change 1 ns after the rising
//   edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_pg_sum_stage;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] p_in = '0;
  logic [WIDTH-1:0] gg_in = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             ovf_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pg_sum_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p_in      (p_in),
    .gg_in     (gg_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .ovf_out   (ovf_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference prefix tree: builds p and the group generates by ripple.
  task automatic model_pg(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          output logic [7:0] p, output logic [7:0] gg);
    logic c;
    c = ci;
    for (int i = 0; i < 8; i++) begin
      p[i]  = a[i] ^ b[i];
      gg[i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      c     = gg[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; p_in = 8'h55; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_out !== 8'h00 ||
        cout_out !== 1'b0 || ovf_out !== 1'b0) begin
      bad++;
      $display("FAIL reset: valid=%b ready=%b sum=%h cout=%b ovf=%b required 0 1 00 0 0",
               out_valid, in_ready, sum_out, cout_out, ovf_out);
    end
    $display("reset: valid=%b ready=%b sum=%h", out_valid, in_ready, sum_out);
  endtask

  task automatic arith_vec(input string name, input logic [7:0] p, input logic [7:0] g,
                           input logic ci, input logic [7:0] es, input logic ec, input logic eo);
    out_ready = 1'b1; in_valid = 1'b1; p_in = p; gg_in = g; cin = ci;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || sum_out !== es || cout_out !== ec || ovf_out !== eo) begin
      bad++;
      $display("FAIL %s: valid=%b sum=%h cout=%b ovf=%b required 1 %h %b %b",
               name, out_valid, sum_out, cout_out, ovf_out, es, ec, eo);
    end
    $display("%s: p=%h gg=%h cin=%b -> sum=%h cout=%b ovf=%b", name, p, g, ci,
             sum_out, cout_out, ovf_out);
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: valid=%b required 0", name, out_valid);
    end
  endtask

  task automatic test_arith();
    arith_vec("arith_ovf",  8'h7E, 8'h7F, 1'b0, 8'h80, 1'b0, 1'b1);
    arith_vec("arith_cout", 8'hFE, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0);
    arith_vec("arith_cin",  8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; gg_in = 8'h00; cin = 1'b0;
    in_valid = 1'b1; p_in = 8'h01;             // W1
    tick();
    total++;
    if (out_valid !== 1'b1 || sum_out !== 8'h01 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_w1: valid=%b sum=%h ready=%b required 1 01 1", out_valid, sum_out, in_ready);
    end
    p_in = 8'h02;                              // W2 goes to skid
    tick();
    total++;
    if (in_ready !== 1'b0 || sum_out !== 8'h01) begin
      bad++;
      $display("FAIL bp_skid: ready=%b sum=%h required 0 01", in_ready, sum_out);
    end
    p_in = 8'h03;                              // W3 offered but refused
    tick();
    total++;
    if (in_ready !== 1'b0 || sum_out !== 8'h01 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_hold: ready=%b sum=%h valid=%b required 0 01 1", in_ready, sum_out, out_valid);
    end
    $display("bp: held sum=%h ready=%b", sum_out, in_ready);
    out_ready = 1'b1;
    tick();                                    // W1 leaves, W2 to main
    total++;
    if (sum_out !== 8'h02 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_w2: sum=%h ready=%b valid=%b required 02 1 1", sum_out, in_ready, out_valid);
    end
    tick();                                    // W2 leaves, W3 in
    in_valid = 1'b0;
    total++;
    if (sum_out !== 8'h03 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_w3: sum=%h valid=%b required 03 1", sum_out, out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: valid=%b required 0", out_valid);
    end
    $display("bp: order 01,02,03 done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_sum;
    out_ready = 1'b1; gg_in = 8'h00;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; p_in = 8'(k * 13); cin = k[0];
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_ready[%0d]: ready=%b required 1", k, in_ready);
      end
      // With gg=0, only bit 0 receives a carry (cin).
      exp_sum = 8'(k * 13) ^ {7'b0, k[0]};
      tick();
      total++;
      if (out_valid !== 1'b1 || sum_out !== exp_sum) begin
        bad++;
        $display("FAIL stream[%0d]: valid=%b sum=%h required 1 %h", k, out_valid, sum_out, exp_sum);
      end
      $display("stream[%0d]: sum=%h", k, sum_out);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_drain: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [9:0]  exp_q[$];
    logic [7:0]  a, b, p, g;
    logic        ci;
    logic [8:0]  full;
    logic [9:0]  exp_w;
    int          sent, recv, cycles;
    bit          in_fire, out_fire;
    sent = 0; recv = 0; cycles = 0;
    in_valid = 1'b0;
    while (recv < 1000 && cycles < 20000) begin
      if (sent < 1000 && !in_valid && ($urandom_range(0, 3) != 0)) begin
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        model_pg(a, b, ci, p, g);
        full = {1'b0, a} + {1'b0, b} + {8'b0, ci};
        exp_w = {full[7:0], full[8], (a[7] == b[7]) && (full[7] != a[7])};
        p_in = p; gg_in = g; cin = ci; in_valid = 1'b1;
      end
      out_ready = 1'($urandom);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra: unexpected word sum=%h", sum_out);
        end else begin
          if ({sum_out, cout_out, ovf_out} !== exp_q[0]) begin
            bad++;
            $display("FAIL rand[%0d]: sum=%h cout=%b ovf=%b required %h %b %b", recv,
                     sum_out, cout_out, ovf_out, exp_q[0][9:2], exp_q[0][1], exp_q[0][0]);
          end
          void'(exp_q.pop_front());
        end
        recv++;
      end
      if (in_fire) begin
        exp_q.push_back(exp_w);
        sent++;
      end
      tick();
      if (in_fire) in_valid = 1'b0;
      cycles++;
    end
    in_valid = 1'b0;
    total++;
    if (recv != 1000 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_count: received=%0d left=%0d required 1000 0", recv, exp_q.size());
    end
    $display("random: sent=%0d received=%0d cycles=%0d", sent, recv, cycles);
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_skid();
    out_ready = 1'b0; gg_in = 8'h00; cin = 1'b0;
    in_valid = 1'b1; p_in = 8'h11;
    tick();
    p_in = 8'h22;
    tick();
    total++;
    if (in_ready !== 1'b0 || sum_out !== 8'h11) begin
      bad++;
      $display("FAIL rskid_fill: ready=%b sum=%h required 0 11", in_ready, sum_out);
    end
    rst = 1'b1; p_in = 8'h33;                  // in_valid stays high, must be ignored
    tick();
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_out !== 8'h00) begin
      bad++;
      $display("FAIL rskid_reset: valid=%b ready=%b sum=%h required 0 1 00",
               out_valid, in_ready, sum_out);
    end
    in_valid = 1'b1; p_in = 8'h44;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || sum_out !== 8'h44) begin
      bad++;
      $display("FAIL rskid_first: valid=%b sum=%h required 1 44", out_valid, sum_out);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rskid_alone: valid=%b sum=%h required valid 0", out_valid, sum_out);
    end
    $display("reset_skid: first word 44 emerged alone");
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_skid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pg_sum_stage.md
Name: pg_sum_stage

Overview:
- Post-processing stage of the parallel-prefix adder; sits directly downstream of the dot-operator prefix tree.
- Consumes the per-bit propagate vector and the prefix group-generate vector G[i:0] produced by the tree.
- Forms sum, carry-out and signed overflow, and registers them behind a valid/ready handshake.
- Includes a 2-entry skid buffer so the tree pipeline can stall without combinational ready paths.

Parameters:
- WIDTH, 8, operand/sum width in bits (>=2).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage can accept a word; registered.
- p_in  input  WIDTH  bitwise propagate, a^b.
- gg_in  input  WIDTH  group generate; gg_in[i] = G[i:0] including cin = carry into bit i+1.
- cin  input  1  carry-in used for bit 0.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts.
- sum_out  output  WIDTH  registered sum.
- cout_out  output  1  carry-out = gg_in[WIDTH-1].
- ovf_out  output  1  signed overflow = c[WIDTH] ^ c[WIDTH-1].

Behaviour:
- Arithmetic (combinational, before capture):
  - Carry vector: c[0]=cin; c[i]=gg_in[i-1] for 1<=i<=WIDTH-1; c[WIDTH]=gg_in[WIDTH-1].
  - sum[i] = p_in[i] ^ c[i].
  - No width growth; carry is reported only via cout_out.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Words are never dropped, duplicated or reordered.
  - in_valid is not required to stay high after a refused cycle, but payload is sampled only on transfer.
- Storage: main register (drives outputs) plus one skid register. States:
  - EMPTY: out_valid=0, in_ready=1. Input transfer -> FULL, main loaded; latency 1 cycle.
  - FULL: out_valid=1, in_ready=1.
    - Input and output transfer together: main reloaded with new word, stay FULL.
    - Output transfer only: -> EMPTY.
    - Input transfer only (out_ready=0): new word goes to skid -> SKID.
  - SKID: out_valid=1, in_ready=0.
    - Output transfer: skid moves to main -> FULL.
    - Otherwise hold all contents.
- in_ready is a flop output (1 unless SKID); no combinational path from out_ready to in_ready.
- Reset:
  - Synchronous reset -> EMPTY; sum_out=0, cout_out=0, ovf_out=0, out_valid=0, in_ready=1; skid contents cleared.
  - Reset asserted mid-operation discards all held words; in_valid is ignored during the reset cycle.
- Outputs are stable while out_valid=1 and out_ready=0.

Test Plan:
- WIDTH=8: p_in=0x7E, gg_in=0x7F, cin=0, out_ready=1 -> next cycle out_valid=1, sum_out=0x80, cout_out=0, ovf_out=1.
- p_in=0xFE, gg_in=0xFF, cin=0 -> sum_out=0x00, cout_out=1, ovf_out=0; p_in=0xFF, gg_in=0xFF, cin=1 -> sum_out=0x00, cout_out=1, ovf_out=0.
- Backpressure:
  - out_ready=0; send words W1=(0x01,0x00,0), W2=(0x02,0x00,0).
  - Expected: in_ready=0 the cycle after W2; W3 held off; sum_out stays 0x01.
  - Raise out_ready: outputs 0x01, 0x02, then W3 in order.
- Streaming: 16 back-to-back words with out_ready=1 -> one word out per cycle, in_ready never drops, 1-cycle latency.
- Random out_ready toggling over 1000 random (a,b,cin) with reference-model p/gg -> every sum/cout/ovf matches a+b+cin; no loss or duplication.
- Reset while in SKID with two words held -> next cycle out_valid=0, in_ready=1, sum_out=0; first post-reset word emerges alone.
